// File: rtl/cve2_mem_arbiter_if.sv
// Bundle of the instruction, data and shared-memory ports of cve2_mem_arbiter.
// slave = arbiter view, master = requester/memory environment view.
interface cve2_mem_arbiter_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );
endinterface

// File: rtl/cve2_mem_arbiter.sv
// Two-requester (instr/data) arbiter onto one memory port with in-order response routing.
// Define CVE2_ARB_RR_EN for round-robin priority; default is fixed data-first priority.
module cve2_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  cve2_mem_arbiter_if.slave bus,
  output logic              busy_o
);
  localparam int unsigned     CntW    = $clog2(MaxOutstanding + 1);
  localparam int unsigned     PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(MaxOutstanding);

  typedef enum logic {IDLE, WAIT_GNT} state_e;

  state_e                  state_q, state_d;
  logic                    sel_q, sel_d;
  logic                    sel, pri_sel;
  logic                    allow_req, grant, pop, head_id;
  logic [MaxOutstanding-1:0] id_fifo_q;
  logic [PtrW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]         cnt_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

`ifdef CVE2_ARB_RR_EN
  // last_q = 1 means data was granted last, so instr wins the next tie.
  logic last_q;

  always_comb begin
    if (bus.instr_req_i && bus.data_req_i) pri_sel = ~last_q;
    else                                   pri_sel = bus.data_req_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    last_q <= 1'b1;
    else if (grant) last_q <= sel;
  end
`else
  assign pri_sel = bus.data_req_i;
`endif

  // A stalled request keeps its source so the memory payload cannot switch under it.
  assign sel       = (state_q == WAIT_GNT) ? sel_q : pri_sel;
  assign allow_req = (cnt_q != FullCnt) || bus.mem_rvalid_i;
  assign grant     = bus.mem_req_o & bus.mem_gnt_i;
  assign pop       = bus.mem_rvalid_i & (cnt_q != '0);
  assign head_id   = id_fifo_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_req_o && !bus.mem_gnt_i) begin
          state_d = WAIT_GNT;
          sel_d   = sel;
        end
      end
      WAIT_GNT: begin
        if (!bus.mem_req_o || bus.mem_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (grant) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({grant, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ID storage is qualified by the pointers/count, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (grant) id_fifo_q[wr_ptr_q] <= sel;
  end

  assign bus.mem_req_o   = rst_ni & allow_req & (sel ? bus.data_req_i : bus.instr_req_i);
  assign bus.mem_we_o    = sel & bus.data_we_i;
  assign bus.mem_be_o    = sel ? bus.data_be_i : 4'hF;
  assign bus.mem_addr_o  = sel ? bus.data_addr_i : bus.instr_addr_i;
  assign bus.mem_wdata_o = sel ? bus.data_wdata_i : 32'h0;

  assign bus.instr_gnt_o = grant & ~sel;
  assign bus.data_gnt_o  = grant & sel;

  assign bus.instr_rvalid_o = pop & ~head_id;
  assign bus.data_rvalid_o  = pop & head_id;
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;
  assign bus.instr_err_o    = bus.mem_err_i;
  assign bus.data_err_o     = bus.mem_err_i;

  assign busy_o = rst_ni & ((cnt_q != '0) | bus.mem_req_o);
endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// Directed table-driven bench for cve2_mem_arbiter (MaxOutstanding = 2), plus reset and
// priority sequences; the priority sequence expects round-robin when CVE2_ARB_RR_EN is defined.
module tb_cve2_mem_arbiter;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  typedef struct {
    string       name;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        err;
    logic        e_req;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_igt;
    logic        e_dgt;
    logic        e_irv;
    logic        e_drv;
    logic        e_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_ni;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  cve2_mem_arbiter_if bus();

  cve2_mem_arbiter #(.MaxOutstanding(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus),
    .busy_o (busy)
  );

  task automatic drive(input vec_t v);
    bus.instr_req_i  = v.ireq;
    bus.instr_addr_i = v.iaddr;
    bus.data_req_i   = v.dreq;
    bus.data_we_i    = v.dwe;
    bus.data_be_i    = v.dbe;
    bus.data_addr_i  = v.daddr;
    bus.data_wdata_i = v.dwdata;
    bus.mem_gnt_i    = v.gnt;
    bus.mem_rvalid_i = v.rv;
    bus.mem_rdata_i  = v.rdata;
    bus.mem_err_i    = v.err;
  endtask

  // Drive one cycle's inputs, then compare all outputs 1 time unit later (away from posedge).
  task automatic step(input vec_t v);
    logic [140:0] got, exp;
    drive(v);
    #1;
    got = {bus.mem_req_o,
           v.e_req ? {bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} : 69'd0,
           bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o, bus.data_rvalid_o,
           bus.instr_rdata_o, bus.data_rdata_o, bus.instr_err_o, bus.data_err_o, busy};
    exp = {v.e_req,
           v.e_req ? {v.e_we, v.e_be, v.e_addr, v.e_wdata} : 69'd0,
           v.e_igt, v.e_dgt, v.e_irv, v.e_drv,
           v.rdata, v.rdata, v.err, v.err, v.e_busy};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", v.name, got, exp);
    end
  endtask

  initial begin
    vec_t v;
    logic g [0:4];
    vec_t idle;

    idle = '{"idle", N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, N, 32'h0, N,
             N, N, 4'h0, 32'h0, 32'h0, N, N, N, N, N};

    // name, ireq iaddr, dreq dwe dbe daddr dwdata, gnt rv rdata err |
    // e_req e_we e_be e_addr e_wdata, e_igt e_dgt e_irv e_drv e_busy
    vq.push_back('{"both_req_data_first", Y, 32'h40, Y, N, 4'hF, 32'h100, 32'h0, Y, N, 32'h0, N,
                   Y, N, 4'hF, 32'h100, 32'h0, N, Y, N, N, Y});
    vq.push_back('{"instr_served_next", Y, 32'h40, N, N, 4'hF, 32'h100, 32'h0, Y, N, 32'h0, N,
                   Y, N, 4'hF, 32'h40, 32'h0, Y, N, N, N, Y});
    vq.push_back('{"rsp_routed_data", N, 32'h40, N, N, 4'hF, 32'h100, 32'h0, N, Y, 32'h11111111, N,
                   N, N, 4'h0, 32'h0, 32'h0, N, N, N, Y, Y});
    vq.push_back('{"rsp_routed_instr", N, 32'h40, N, N, 4'hF, 32'h100, 32'h0, N, Y, 32'h22222222, N,
                   N, N, 4'h0, 32'h0, 32'h0, N, N, Y, N, Y});
    vq.push_back('{"rsp_empty_dropped", N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, Y, 32'h33333333, N,
                   N, N, 4'h0, 32'h0, 32'h0, N, N, N, N, N});
    vq.push_back('{"lock_c0_instr", Y, 32'h80, N, N, 4'h0, 32'h0, 32'h0, N, N, 32'h0, N,
                   Y, N, 4'hF, 32'h80, 32'h0, N, N, N, N, Y});
    vq.push_back('{"lock_c1_data_rises", Y, 32'h80, Y, Y, 4'h5, 32'h200, 32'hCAFEF00D, N, N, 32'h0, N,
                   Y, N, 4'hF, 32'h80, 32'h0, N, N, N, N, Y});
    vq.push_back('{"lock_c2_held", Y, 32'h80, Y, Y, 4'h5, 32'h200, 32'hCAFEF00D, N, N, 32'h0, N,
                   Y, N, 4'hF, 32'h80, 32'h0, N, N, N, N, Y});
    vq.push_back('{"lock_c3_instr_gnt", Y, 32'h80, Y, Y, 4'h5, 32'h200, 32'hCAFEF00D, Y, N, 32'h0, N,
                   Y, N, 4'hF, 32'h80, 32'h0, Y, N, N, N, Y});
    vq.push_back('{"data_write_served", N, 32'h80, Y, Y, 4'h5, 32'h200, 32'hCAFEF00D, Y, N, 32'h0, N,
                   Y, Y, 4'h5, 32'h200, 32'hCAFEF00D, N, Y, N, N, Y});
    vq.push_back('{"full_blocks_req", Y, 32'h84, N, N, 4'h0, 32'h0, 32'h0, Y, N, 32'h0, N,
                   N, N, 4'h0, 32'h0, 32'h0, N, N, N, N, Y});
    vq.push_back('{"full_pop_then_push", Y, 32'h84, N, N, 4'h0, 32'h0, 32'h0, Y, Y, 32'h44444444, N,
                   Y, N, 4'hF, 32'h84, 32'h0, Y, N, Y, N, Y});
    vq.push_back('{"data_write_err_rsp", N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, Y, 32'h55555555, Y,
                   N, N, 4'h0, 32'h0, 32'h0, N, N, N, Y, Y});
    vq.push_back('{"instr_rsp_after_err", N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, Y, 32'h66666666, N,
                   N, N, 4'h0, 32'h0, 32'h0, N, N, Y, N, Y});
    vq.push_back('{"idle_not_busy", N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, N, 32'h0, N,
                   N, N, 4'h0, 32'h0, 32'h0, N, N, N, N, N});
    vq.push_back('{"instr_gnt_a", Y, 32'h90, N, N, 4'h0, 32'h0, 32'h0, Y, N, 32'h0, N,
                   Y, N, 4'hF, 32'h90, 32'h0, Y, N, N, N, Y});
    vq.push_back('{"instr_gnt_b", Y, 32'h94, N, N, 4'h0, 32'h0, 32'h0, Y, N, 32'h0, N,
                   Y, N, 4'hF, 32'h94, 32'h0, Y, N, N, N, Y});
    vq.push_back('{"full_two_instr", Y, 32'h98, N, N, 4'h0, 32'h0, 32'h0, Y, N, 32'h0, N,
                   N, N, 4'h0, 32'h0, 32'h0, N, N, N, N, Y});
    vq.push_back('{"full_rvalid_same_gnt", Y, 32'h98, N, N, 4'h0, 32'h0, 32'h0, Y, Y, 32'h77777777, N,
                   Y, N, 4'hF, 32'h98, 32'h0, Y, N, Y, N, Y});
    vq.push_back('{"count_two_drain_a", N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, Y, 32'h88888888, N,
                   N, N, 4'h0, 32'h0, 32'h0, N, N, Y, N, Y});
    vq.push_back('{"count_two_drain_b", N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, Y, 32'h99999999, N,
                   N, N, 4'h0, 32'h0, 32'h0, N, N, Y, N, Y});
    vq.push_back('{"drained_idle", N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, N, 32'h0, N,
                   N, N, 4'h0, 32'h0, 32'h0, N, N, N, N, N});

    // Reset state with both requesters and a stray response active.
    rst_ni = 1'b0;
    drive(idle);
    @(negedge clk);
    step('{"reset_outputs", Y, 32'h40, Y, N, 4'hF, 32'h100, 32'h0, Y, Y, 32'h0, N,
           N, N, 4'h0, 32'h0, 32'h0, N, N, N, N, N});
    @(negedge clk);
    drive(idle);
    rst_ni = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      step(vq[i]);
    end

    // Reset with two transactions outstanding; later responses must be dropped.
    @(negedge clk);
    step('{"rst_seq_gnt_a", Y, 32'hA0, N, N, 4'h0, 32'h0, 32'h0, Y, N, 32'h0, N,
           Y, N, 4'hF, 32'hA0, 32'h0, Y, N, N, N, Y});
    @(negedge clk);
    step('{"rst_seq_gnt_b", Y, 32'hA4, N, N, 4'h0, 32'h0, 32'h0, Y, N, 32'h0, N,
           Y, N, 4'hF, 32'hA4, 32'h0, Y, N, N, N, Y});
    @(negedge clk);
    rst_ni = 1'b0;
    step('{"rst_seq_in_reset", Y, 32'hA8, Y, N, 4'hF, 32'h100, 32'h0, Y, Y, 32'hAAAAAAAA, N,
           N, N, 4'h0, 32'h0, 32'h0, N, N, N, N, N});
    @(negedge clk);
    rst_ni = 1'b1;
    step('{"rst_seq_rsp_dropped", N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, Y, 32'hBBBBBBBB, N,
           N, N, 4'h0, 32'h0, 32'h0, N, N, N, N, N});
    @(negedge clk);
    step('{"rst_seq_rsp_dropped2", N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, Y, 32'hCCCCCCCC, N,
           N, N, 4'h0, 32'h0, 32'h0, N, N, N, N, N});

    // Priority under contention: one instr grant, then both held with a response each cycle
    // so the count stays at 1. g[k] = 1 when data wins cycle k.
    g[0] = 1'b0;
    for (int k = 1; k < 5; k++) begin
`ifdef CVE2_ARB_RR_EN
      g[k] = ~g[k-1];
`else
      g[k] = 1'b1;
`endif
    end
    @(negedge clk);
    step('{"prio_seed_instr", Y, 32'hC0, N, N, 4'h0, 32'h0, 32'h0, Y, N, 32'h0, N,
           Y, N, 4'hF, 32'hC0, 32'h0, Y, N, N, N, Y});
    for (int k = 1; k < 5; k++) begin
      v = '{"prio_contention", Y, 32'hC0, Y, N, 4'hF, 32'h300, 32'h0, Y, Y, 32'hD0 + 32'(k), N,
            Y, N, 4'hF, g[k] ? 32'h300 : 32'hC0, 32'h0, ~g[k], g[k], ~g[k-1], g[k-1], Y};
      @(negedge clk);
      step(v);
    end
    v = '{"prio_drain", N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, Y, 32'hE0, N,
          N, N, 4'h0, 32'h0, 32'h0, N, N, ~g[4], g[4], Y};
    @(negedge clk);
    step(v);
    @(negedge clk);
    step('{"prio_idle", N, 32'h0, N, N, 4'h0, 32'h0, 32'h0, N, N, 32'h0, N,
           N, N, 4'h0, 32'h0, 32'h0, N, N, N, N, N});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cve2_mem_arbiter.md
CVE2_MEM_ARBITER -- requirements
Module: cve2_mem_arbiter

Interface
REQ-001 The block SHALL have parameter MaxOutstanding, default 2, meaning the maximum number of granted-but-unanswered memory transactions (legal range 1..4).
REQ-002 The block SHALL have port clk_i, input, 1, clock; reset rst_ni, asynchronous, active-low; clock clk_i.
REQ-003 The block SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports instr_req_i (input, 1), instr_addr_i (input, 32), instr_gnt_o (output, 1), instr_rvalid_o (output, 1), instr_rdata_o (output, 32) and instr_err_o (output, 1), forming the read-only instruction requester port.
REQ-005 The block SHALL have ports data_req_i (input, 1), data_we_i (input, 1), data_be_i (input, 4), data_addr_i (input, 32), data_wdata_i (input, 32), data_gnt_o (output, 1), data_rvalid_o (output, 1), data_rdata_o (output, 32) and data_err_o (output, 1), forming the data requester port.
REQ-006 The block SHALL have ports mem_req_o (output, 1), mem_we_o (output, 1), mem_be_o (output, 4), mem_addr_o (output, 32), mem_wdata_o (output, 32), mem_gnt_i (input, 1), mem_rvalid_i (input, 1), mem_rdata_i (input, 32) and mem_err_i (input, 1), forming the shared memory port.
REQ-007 The block SHALL have port busy_o, output, 1, which is high while any transaction is outstanding or mem_req_o is high.

Function
REQ-008 Arbitration: an unlocked, non-full arbiter SHALL forward a request combinationally in the same cycle, with zero latency from requester request to mem_req_o.
REQ-009 Fixed priority SHALL apply, data over instruction, when CVE2_ARB_RR_EN is undefined.
REQ-010 Lock: while mem_req_o=1 and mem_gnt_i=0, the selected source SHALL be held in a register (states IDLE -> WAIT_GNT -> IDLE on gnt), and the mem_* payload SHALL stay stable even if the other requester asserts.
REQ-011 Payload: with instruction selected, the block SHALL drive mem_we_o=0, mem_be_o=4'hF and mem_wdata_o=0; with data selected, it SHALL pass through the data_* fields.
REQ-012 Grant: the block SHALL drive <src>_gnt_o = mem_gnt_i & mem_req_o & (selected == src), and never both grants in one cycle.
REQ-013 ID FIFO: on each granted cycle, the block SHALL push the source ID (0=instr, 1=data) into an in-order FIFO of depth MaxOutstanding with wrapping read/write pointers.
REQ-014 Response routing: on mem_rvalid_i, the block SHALL assert <src>_rvalid_o for the FIFO head ID only, pass mem_rdata_i/mem_err_i combinationally to both rdata/err outputs, and pop the head.
REQ-015 Full: when outstanding count equals MaxOutstanding, the block SHALL hold mem_req_o=0 and both grants 0, unless mem_rvalid_i=1 in that cycle (pop-before-push permitted).
REQ-016 A simultaneous grant and response SHALL leave the count unchanged, with head and tail both advancing.
REQ-017 A mem_rvalid_i arriving with an empty FIFO SHALL be dropped, asserting neither rvalid output and leaving the count at 0.
REQ-018 The block SHALL compute the count in $clog2(MaxOutstanding+1) bits with no overflow or underflow.

Reset
REQ-019 Asserting reset SHALL clear the FIFO, set count=0, set the lock state to IDLE and set the RR pointer to instr-priority.
REQ-020 Outputs SHALL be 0 in reset: mem_req_o, both grants, both rvalids and busy_o.
REQ-021 Reset mid-transaction SHALL discard outstanding IDs, so that responses arriving after reset are dropped per REQ-017.

Configuration
REQ-022 Macro CVE2_ARB_RR_EN, when defined, SHALL enable round-robin: a 1-bit last-granted register, updated on each grant, gives priority to the source not last granted.
REQ-023 When CVE2_ARB_RR_EN is undefined, the block SHALL use fixed data-first priority with no last-granted register.

Verification
REQ-024 Both requesters asserted in cycle 0 with mem_gnt_i=1 (fixed priority) -> data_gnt_o=1 in cycle 0, instr_gnt_o=1 in cycle 1, and rvalids routed data then instr.
REQ-025 instr_req_i=1 at addr 0x80 with mem_gnt_i=0 for 3 cycles, data_req_i rising in cycle 1 -> mem_addr_o stays 0x80 and mem_we_o=0 until the cycle-3 grant, then data is served.
REQ-026 MaxOutstanding=2 with two instr grants and no response -> a third request sees mem_req_o=0; mem_rvalid_i in the next cycle with a request pending -> grant in the same cycle with count remaining 2.
REQ-027 Data write with mem_err_i=1 on the response -> data_rvalid_o=1, data_err_o=1, instr_rvalid_o=0.
REQ-028 With CVE2_ARB_RR_EN defined and both requests held continuously with gnt=1 -> grants alternate data, instr, data, instr.
REQ-029 Reset asserted with 2 outstanding, then released, followed by mem_rvalid_i=1 -> no rvalid output and busy_o=0.
